// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, optional
// parity bit, stop bit. One bit per clock, no oversampling. All state moves
// on the falling clock edge to line up with the upstream flip-flop stage.
module serial_frame_rx #(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DATA      = 3'd1;
   localparam logic [2:0] S_PARITY    = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   localparam int              CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   logic [2:0]           state;
   logic [2:0]           next_state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shifted;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 par_mismatch;

   // Next-state decode for the frame sequencer.
   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (!din) next_state = S_DATA;
         S_DATA:      if (bit_cnt == LAST_BIT) next_state = PARITY_EN ? S_PARITY : S_STOP;
         S_PARITY:    next_state = S_STOP;
         S_STOP:      next_state = din ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (din) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   // Shift register contents after accepting the current line bit at the MSB,
   // so the first data bit ends up in bit 0 once the frame is complete.
   always_comb begin
      shifted                = shift_reg >> 1;
      shifted[DATA_BITS-1]   = din;
   end

   // State register; busy is registered from the next state so it reflects
   // "not in IDLE" in the same cycle the state does.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(negedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != S_IDLE);
      end
   end

   // Datapath: bit counter, shift register, parity latch and output strobes.
   // NOTE: reset clears every datapath flop so a mid-frame reset leaves no stale word or pulse.
   always_ff @(negedge clk) begin
      if (rst) begin
         shift_reg    <= '0;
         bit_cnt      <= '0;
         par_mismatch <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               bit_cnt      <= '0;
               par_mismatch <= 1'b0;
            end
            S_DATA: begin
               shift_reg <= shifted;
               bit_cnt   <= bit_cnt + 1'b1;
            end
            S_PARITY: begin
               par_mismatch <= (^shift_reg) ^ din ^ ODD_PARITY;
            end
            S_STOP: begin
               if (din) begin
                  data_out   <= shift_reg;
                  data_valid <= 1'b1;
                  parity_err <= PARITY_EN & par_mismatch;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
